dfs_ctrl: RTL and testbench

DFS_CTRL -- requirements
Module: dfs_ctrl

---
 rtl/dfs_ctrl.sv | 80 ++++++++
 tb/tb_dfs_ctrl.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/dfs_ctrl.sv
// Dynamic frequency-switch controller: drives the clock-source select, waits a settle
// period before confirming the new mode, then enforces a dwell before the next request.
module dfs_ctrl #(
  parameter int SETTLE_CYC = 8,
  parameter int HOLD_CYC   = 16
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       req_valid,
  input  logic       req_fast,
  output logic       req_ready,
  output logic       sel,
  output logic       cur_fast,
  output logic       busy,
  output logic       done,
  output logic [7:0] sw_cnt
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SWITCH = 2'd1,
    HOLD   = 2'd2
  } state_t;

  // Counter reload values; both parameters are limited to 1..256 so N-1 fits in 8 bits.
  localparam logic [7:0] SETTLE_LD = 8'(SETTLE_CYC - 1);
  localparam logic [7:0] HOLD_LD   = 8'(HOLD_CYC - 1);

  state_t     state;
  logic [7:0] cnt;

  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      sel      <= 1'b0;
      cur_fast <= 1'b0;
      done     <= 1'b0;
      sw_cnt   <= 8'd0;
      cnt      <= 8'd0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            if (req_fast == cur_fast) begin
              done <= 1'b1;
            end else begin
              sel   <= req_fast;
              cnt   <= SETTLE_LD;
              state <= SWITCH;
            end
          end
        end
        SWITCH: begin
          if (cnt != 8'd0) begin
            cnt <= cnt - 8'd1;
          end else begin
            cur_fast <= sel;
            done     <= 1'b1;
            if (sw_cnt != 8'hff) sw_cnt <= sw_cnt + 8'd1;
            cnt      <= HOLD_LD;
            state    <= HOLD;
          end
        end
        HOLD: begin
          if (cnt != 8'd0) cnt <= cnt - 8'd1;
          else             state <= IDLE;
        end
        default: begin
          state <= IDLE;
          cnt   <= 8'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dfs_ctrl.sv
// Directed bench for dfs_ctrl at SETTLE_CYC=8, HOLD_CYC=16.
module tb_dfs_ctrl;

  logic       clk;
  logic       rstn;
  logic       req_valid;
  logic       req_fast;
  logic       req_ready;
  logic       sel;
  logic       cur_fast;
  logic       busy;
  logic       done;
  logic [7:0] sw_cnt;

  int n_cmp = 0;
  int n_err = 0;

  int  cyc = 0;
  int  last_tog = 0;
  int  tog_viol = 0;
  int  tog_seen = 0;
  bit  mon_en = 0;
  logic prev_sel = 0;

  dfs_ctrl #(.SETTLE_CYC(8), .HOLD_CYC(16)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .req_valid (req_valid),
    .req_fast  (req_fast),
    .req_ready (req_ready),
    .sel       (sel),
    .cur_fast  (cur_fast),
    .busy      (busy),
    .done      (done),
    .sw_cnt    (sw_cnt)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  // Watches sel for toggles closer than 24 cycles apart while enabled.
  always @(negedge clk) begin
    if (!mon_en) begin
      prev_sel = sel;
      tog_seen = 0;
    end else if (sel !== prev_sel) begin
      if (tog_seen != 0 && (cyc - last_tog) < 24) tog_viol++;
      tog_seen = 1;
      last_tog = cyc;
      prev_sel = sel;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int waited;
    rstn      = 0;
    req_valid = 0;
    req_fast  = 0;

    // Reset state, checked before any clock edge.
    #3;
    chk("rst_sel",   sel,       0);
    chk("rst_cur",   cur_fast,  0);
    chk("rst_ready", req_ready, 1);
    chk("rst_busy",  busy,      0);
    chk("rst_cnt",   sw_cnt,    0);
    chk("rst_done",  done,      0);

    // Request fast mode right after reset release; accepted on first edge (N).
    @(negedge clk);
    rstn      = 1;
    req_valid = 1;
    req_fast  = 1;
    tick();
    req_valid = 0;
    chk("sw1_sel_n",    sel,       1);
    chk("sw1_busy_n",   busy,      1);
    chk("sw1_ready_n",  req_ready, 0);
    tick(7);
    chk("sw1_done_n7",  done,      0);
    chk("sw1_cur_n7",   cur_fast,  0);
    tick();
    chk("sw1_done_n8",  done,      1);
    chk("sw1_cur_n8",   cur_fast,  1);
    chk("sw1_cnt_n8",   sw_cnt,    1);
    // Hold a slow request during HOLD; it must wait for req_ready.
    req_valid = 1;
    req_fast  = 0;
    tick();
    chk("sw1_done_n9",  done,      0);
    tick(14);
    chk("hold_ready_n23", req_ready, 0);
    chk("hold_sel_n23",   sel,       1);
    tick();
    chk("hold_ready_n24", req_ready, 1);
    chk("hold_sel_n24",   sel,       1);
    tick();
    req_valid = 0;
    chk("sw2_sel",   sel,  0);
    chk("sw2_busy",  busy, 1);
    tick(8);
    chk("sw2_done",  done,     1);
    chk("sw2_cur",   cur_fast, 0);
    chk("sw2_cnt",   sw_cnt,   2);
    tick(16);
    chk("sw2_ready", req_ready, 1);

    // Three back-to-back same-mode requests.
    req_valid = 1;
    req_fast  = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("same_done%0d", i), done, 1);
      chk($sformatf("same_busy%0d", i), busy, 0);
    end
    req_valid = 0;
    tick();
    chk("same_done_end", done,   0);
    chk("same_sel",      sel,    0);
    chk("same_cnt",      sw_cnt, 2);

    // Reset 3 cycles into a switch toward fast.
    req_valid = 1;
    req_fast  = 1;
    tick();
    req_valid = 0;
    tick(3);
    chk("ab_busy_pre", busy, 1);
    chk("ab_sel_pre",  sel,  1);
    rstn = 0;
    #1;
    chk("ab_sel",   sel,       0);
    chk("ab_cur",   cur_fast,  0);
    chk("ab_ready", req_ready, 1);
    chk("ab_busy",  busy,      0);
    chk("ab_cnt",   sw_cnt,    0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("ab_done%0d", i), done, 0);
    end

    // 300 alternating requests; first one is taken on the first edge after release.
    @(negedge clk);
    rstn   = 1;
    mon_en = 1;
    for (int i = 0; i < 300; i++) begin
      req_valid = 1;
      req_fast  = (i % 2 == 0);
      tick();
      req_valid = 0;
      if (i == 0) begin
        chk("alt_first_sel",  sel,  1);
        chk("alt_first_busy", busy, 1);
      end
      waited = 0;
      while (!req_ready && waited < 40) begin
        tick();
        waited++;
      end
      if (i == 0) chk("alt_lat", waited, 24);
      if (!req_ready) begin
        chk($sformatf("alt_timeout%0d", i), req_ready, 1);
        break;
      end
      if (i == 253) chk("alt_cnt254", sw_cnt, 254);
      if (i == 254) chk("alt_cnt255", sw_cnt, 255);
    end
    chk("alt_cnt_sat", sw_cnt,   255);
    chk("alt_cur",     cur_fast, 0);
    chk("alt_tog",     tog_viol, 0);
    chk("alt_tog_seen", tog_seen, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
